// File: rtl/psg_pkg.sv
// Shared constants and types for the PSG register controller: latch-byte field
// positions, register type codes and the busy-timer state encoding.
package psg_pkg;

    localparam int LATCH_BIT = 7;
    localparam int CH_MSB    = 6;
    localparam int CH_LSB    = 5;
    localparam int TYPE_BIT  = 4;

    localparam logic       TYPE_TONE  = 1'b0;
    localparam logic       TYPE_ATTEN = 1'b1;
    localparam logic [1:0] NOISE_CH   = 2'd3;
    localparam logic [3:0] ATTEN_OFF  = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } timer_state_t;

endpackage

// File: rtl/psg_ready_timer.sv
// Busy-window timer: after each accepted byte, holds ready low for exactly
// READY_CYCLES cycles. With READY_CYCLES = 0 it never leaves IDLE.
module psg_ready_timer
    import psg_pkg::*;
#(
    parameter int READY_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic ready
);

    localparam int CNT_W = (READY_CYCLES > 2) ? $clog2(READY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((READY_CYCLES > 0) ? READY_CYCLES - 1 : 0);

    timer_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start && (READY_CYCLES > 0)) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/psg_register_controller.sv
// Host-facing SN76489-style register file: decodes latch/data bytes into tone
// periods, attenuations and noise control, with a handshake busy window.
module psg_register_controller
    import psg_pkg::*;
#(
    parameter int COUNTER_BITS = 10,
    parameter int READY_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [COUNTER_BITS-1:0] tone_freq0,
    output logic [COUNTER_BITS-1:0] tone_freq1,
    output logic [COUNTER_BITS-1:0] tone_freq2,
    output logic [3:0]              atten0,
    output logic [3:0]              atten1,
    output logic [3:0]              atten2,
    output logic [3:0]              atten3,
    output logic [2:0]              noise_control,
    output logic                    reset_lfsr
);

    logic [COUNTER_BITS-1:0] tone_q  [3];
    logic [3:0]              atten_q [4];
    logic [1:0]              latch_ch;
    logic                    latch_type;

    logic       accept;
    logic       is_latch;
    logic [1:0] tgt_ch;
    logic       tgt_type;

    assign accept   = wr_valid & wr_ready & ~reset;
    assign is_latch = wr_data[LATCH_BIT];
    // Data bytes carry no address; they reuse whatever the last latch byte selected.
    assign tgt_ch   = is_latch ? wr_data[CH_MSB:CH_LSB] : latch_ch;
    assign tgt_type = is_latch ? wr_data[TYPE_BIT]      : latch_type;

    psg_ready_timer #(
        .READY_CYCLES(READY_CYCLES)
    ) u_ready_timer (
        .clk  (clk),
        .reset(reset),
        .start(accept),
        .ready(wr_ready)
    );

    // NOTE: the register file is a handful of flops with defined power-up values, so it is reset; a RAM would not be.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) tone_q[i]  <= '0;
            for (int i = 0; i < 4; i++) atten_q[i] <= ATTEN_OFF;
            latch_ch      <= 2'd0;
            latch_type    <= TYPE_TONE;
            noise_control <= 3'd0;
            reset_lfsr    <= 1'b0;
        end else begin
            reset_lfsr <= 1'b0;
            if (accept) begin
                if (is_latch) begin
                    latch_ch   <= wr_data[CH_MSB:CH_LSB];
                    latch_type <= wr_data[TYPE_BIT];
                end
                if (tgt_type == TYPE_ATTEN) begin
                    atten_q[tgt_ch] <= wr_data[3:0];
                end else if (tgt_ch == NOISE_CH) begin
                    noise_control <= wr_data[2:0];
                    reset_lfsr    <= 1'b1;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (tgt_ch == 2'(i)) begin
                            if (is_latch) tone_q[i][3:0]              <= wr_data[3:0];
                            else          tone_q[i][COUNTER_BITS-1:4] <= wr_data[COUNTER_BITS-5:0];
                        end
                    end
                end
            end
        end
    end

    assign tone_freq0 = tone_q[0];
    assign tone_freq1 = tone_q[1];
    assign tone_freq2 = tone_q[2];
    assign atten0     = atten_q[0];
    assign atten1     = atten_q[1];
    assign atten2     = atten_q[2];
    assign atten3     = atten_q[3];

endmodule

// File: tb/tb_psg_register_controller.sv
// Directed bench: one instance with no busy window, one with a 32-cycle window.
module tb_psg_register_controller;

    logic clk = 1'b0;
    logic reset;

    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [9:0] a_tone0, a_tone1, a_tone2, b_tone0, b_tone1, b_tone2;
    logic [3:0] a_att0, a_att1, a_att2, a_att3, b_att0, b_att1, b_att2, b_att3;
    logic [2:0] a_noise, b_noise;
    logic       a_lfsr, b_lfsr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    psg_register_controller #(.COUNTER_BITS(10), .READY_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .wr_data(a_data), .wr_valid(a_valid), .wr_ready(a_ready),
        .tone_freq0(a_tone0), .tone_freq1(a_tone1), .tone_freq2(a_tone2),
        .atten0(a_att0), .atten1(a_att1), .atten2(a_att2), .atten3(a_att3),
        .noise_control(a_noise), .reset_lfsr(a_lfsr)
    );

    psg_register_controller #(.COUNTER_BITS(10), .READY_CYCLES(32)) dut_b (
        .clk(clk), .reset(reset), .wr_data(b_data), .wr_valid(b_valid), .wr_ready(b_ready),
        .tone_freq0(b_tone0), .tone_freq1(b_tone1), .tone_freq2(b_tone2),
        .atten0(b_att0), .atten1(b_att1), .atten2(b_att2), .atten3(b_att3),
        .noise_control(b_noise), .reset_lfsr(b_lfsr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One byte through the always-ready instance; returns on the sampling edge after acceptance.
    task automatic write_a(input logic [7:0] d);
        @(negedge clk);
        a_data  = d;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic check_b_reset_state(input string tag);
        check({tag, " tone0"}, 32'(b_tone0), 32'h000);
        check({tag, " tone1"}, 32'(b_tone1), 32'h000);
        check({tag, " tone2"}, 32'(b_tone2), 32'h000);
        check({tag, " atten"}, {16'h0, b_att0, b_att1, b_att2, b_att3}, 32'hFFFF);
        check({tag, " noise"}, 32'(b_noise), 32'h0);
        check({tag, " lfsr"},  32'(b_lfsr), 32'h0);
        check({tag, " ready"}, 32'(b_ready), 32'h1);
    endtask

    initial begin
        int low;
        int n;
        reset   = 1'b1;
        a_data  = 8'h00;
        a_valid = 1'b0;
        b_data  = 8'h00;
        b_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst a tone0", 32'(a_tone0), 32'h0);
        check("rst a atten", {16'h0, a_att0, a_att1, a_att2, a_att3}, 32'hFFFF);
        check("rst a noise", 32'(a_noise), 32'h0);
        check("rst a lfsr",  32'(a_lfsr), 32'h0);
        check("rst a ready", 32'(a_ready), 32'h1);
        check_b_reset_state("rst b");
        reset = 1'b0;

        // 1: tone0 low nibble then upper six bits
        write_a(8'h8E);
        check("t1 tone0 low", 32'(a_tone0), 32'h00E);
        write_a(8'h0F);
        check("t1 tone0",  32'(a_tone0), 32'h0FE);
        check("t1 tone1",  32'(a_tone1), 32'h000);
        check("t1 tone2",  32'(a_tone2), 32'h000);
        check("t1 atten",  {16'h0, a_att0, a_att1, a_att2, a_att3}, 32'hFFFF);
        check("t1 noise",  32'(a_noise), 32'h0);
        check("t1 lfsr",   32'(a_lfsr), 32'h0);

        // 2: noise latch and data writes, one pulse each
        write_a(8'hE5);
        check("t2 noise latch", 32'(a_noise), 32'h5);
        check("t2 pulse1 hi",   32'(a_lfsr), 32'h1);
        @(negedge clk);
        check("t2 pulse1 lo",   32'(a_lfsr), 32'h0);
        write_a(8'h02);
        check("t2 noise data",  32'(a_noise), 32'h2);
        check("t2 pulse2 hi",   32'(a_lfsr), 32'h1);
        @(negedge clk);
        check("t2 pulse2 lo",   32'(a_lfsr), 32'h0);

        // Back-to-back noise writes; bit 3 of 8'h0D must be ignored
        @(negedge clk);
        a_data  = 8'hE1;
        a_valid = 1'b1;
        @(negedge clk);
        check("b2b noise1", 32'(a_noise), 32'h1);
        check("b2b pulse1", 32'(a_lfsr), 32'h1);
        a_data = 8'h0D;
        @(negedge clk);
        a_valid = 1'b0;
        check("b2b noise2", 32'(a_noise), 32'h5);
        check("b2b pulse2", 32'(a_lfsr), 32'h1);
        @(negedge clk);
        check("b2b pulse end", 32'(a_lfsr), 32'h0);
        check("b2b tone0 kept", 32'(a_tone0), 32'h0FE);

        // 3: attenuation latch then data
        write_a(8'hB3);
        check("t3 atten1 latch", 32'(a_att1), 32'h3);
        write_a(8'h07);
        check("t3 atten1 data",  32'(a_att1), 32'h7);
        check("t3 tone1 kept",   32'(a_tone1), 32'h000);
        check("t3 atten0 kept",  32'(a_att0), 32'hF);

        // 6: two data bytes to the same latched tone register
        write_a(8'hA1);
        check("t6 tone1 a", 32'(a_tone1), 32'h001);
        write_a(8'h22);
        check("t6 tone1 b", 32'(a_tone1), 32'h221);
        write_a(8'h33);
        check("t6 tone1 c", 32'(a_tone1), 32'h331);
        check("t6 tone0",   32'(a_tone0), 32'h0FE);
        check("t6 tone2",   32'(a_tone2), 32'h000);

        // Bit 6 of a data byte is outside a 10-bit period
        write_a(8'hC0);
        write_a(8'h7F);
        check("unused bit6", 32'(a_tone2), 32'h3F0);

        // 4: busy window with wr_valid held and a second byte queued
        check("t4 ready idle", 32'(b_ready), 32'h1);
        b_data  = 8'h8A;
        b_valid = 1'b1;
        @(negedge clk);
        check("t4 first byte", 32'(b_tone0), 32'h00A);
        b_data = 8'h05;
        low = 0;
        while (!b_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
        check("t4 low cycles", 32'(low), 32'd32);
        check("t4 tone0 held", 32'(b_tone0), 32'h00A);
        @(negedge clk);
        b_valid = 1'b0;
        check("t4 second byte", 32'(b_tone0), 32'h05A);
        check("t4 busy again",  32'(b_ready), 32'h0);

        // 5: reset five cycles into a busy window
        n = 0;
        while (!b_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t5 ready before", 32'(b_ready), 32'h1);
        b_data  = 8'hC9;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        check("t5 tone2", 32'(b_tone2), 32'h009);
        repeat (4) @(negedge clk);
        check("t5 busy", 32'(b_ready), 32'h0);
        reset   = 1'b1;
        b_data  = 8'h87;
        b_valid = 1'b1;
        repeat (2) @(negedge clk);
        b_valid = 1'b0;
        reset   = 1'b0;
        check_b_reset_state("t5 after rst");
        @(negedge clk);
        check("t5 ready release", 32'(b_ready), 32'h1);
        check("t5 rst byte ignored", 32'(b_tone0), 32'h000);
        b_data  = 8'h3F;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        check("t5 tone0 data", 32'(b_tone0), 32'h3F0);
        check("t5 tone2 clear", 32'(b_tone2), 32'h000);
        check("t5 busy after", 32'(b_ready), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
